uart_rx_cfg: RTL and testbench
==============================

UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 SHALL have parameter INPUT_CLOCK_FREQ, default 100_000_000, clk frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 9600, line bit rate.
REQ-003 SHALL have parameter OVERSAMPLE, default 16, sample ticks per bit; even, >=8.
REQ-004 SHALL have parameter DATA_BITS, default 8, legal range 5..9.
REQ-005 SHALL have parameter PARITY, default PARITY_NONE, of type parity_t (NONE/ODD/EVEN).
REQ-006 SHALL have parameter STOP_BITS, default 1, legal values 1 or 2.
REQ-007 SHALL have port clk, input, 1, rising-edge clock.
REQ-008 SHALL have port rst, input, 1, synchronous active-low reset.
REQ-009 SHALL have port din, input, 1, asynchronous serial line, idle high.
REQ-010 SHALL have port dout, output, DATA_BITS, received word, LSB received first.
REQ-011 SHALL have port dout_valid, output, 1, dout and flags hold a word.
REQ-012 SHALL have port dout_ready, input, 1, consumer accepts word.
REQ-013 SHALL have port parity_err, output, 1, parity mismatch flag for held word.
REQ-014 SHALL have port frame_err, output, 1, stop-bit-low flag for held word.
REQ-015 SHALL have port overrun, output, 1, one-cycle pulse when a completed frame is dropped.

Function
REQ-016 SHALL pass din through a 2-flop synchronizer; all logic uses the synchronized value.
REQ-017 SHALL generate a sample tick every TICK_DIV = INPUT_CLOCK_FREQ/(BAUD_RATE*OVERSAMPLE) clocks; TICK_DIV < 2 or illegal parameters are an elaboration error.
REQ-018 SHALL restart the tick divider and the per-bit tick counter (0..OVERSAMPLE-1) on the clock the IDLE->START transition occurs.
REQ-019 SHALL decide each bit by 2-of-3 majority of samples at ticks OVERSAMPLE/2-1, OVERSAMPLE/2, OVERSAMPLE/2+1; bit boundary at tick OVERSAMPLE-1.
REQ-020 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-021 IDLE->START on synchronized din low.
REQ-022 START: majority 1 at mid-bit -> IDLE (false start, no output, no flags); majority 0 -> DATA at bit end, bit index 0.
REQ-023 DATA: shift majority bit into MSB of a DATA_BITS shift register; after bit DATA_BITS-1 -> PARITY if PARITY != NONE, else STOP.
REQ-024 PARITY: compare majority bit with XOR of data (EVEN) or its inverse (ODD); latch mismatch.
REQ-025 STOP: sample STOP_BITS stop bits; any majority 0 sets frame error; frame completes at mid-bit decision of last stop bit, state -> IDLE on that clock (no wait to bit end).
REQ-026 Completion with holding register empty, or with dout_valid && dout_ready that same clock: load dout, parity_err, frame_err; dout_valid high on next clock.
REQ-027 Completion with dout_valid && !dout_ready: drop new frame, keep held word unchanged, pulse overrun one clock.
REQ-028 dout_valid SHALL clear the clock after dout_valid && dout_ready, unless reloaded per REQ-026.
REQ-029 dout, parity_err, frame_err SHALL be stable while dout_valid high and not accepted.
REQ-030 Frames with errors SHALL still be delivered (flags set), not discarded.
REQ-031 parity_err SHALL be constant 0 when PARITY == NONE.

Reset
REQ-032 On rst low at a clock edge: state IDLE, synchronizer flops 1, counters 0, dout_valid 0, dout 0, parity_err 0, frame_err 0, overrun 0.
REQ-033 Reset mid-frame SHALL abort the frame with no output; receiver resumes on next falling edge after rst high.

Structure
REQ-034 Package uart_pkg SHALL hold parity_t (PARITY_NONE, PARITY_ODD, PARITY_EVEN) and rx_state_t; shared with future uart_tx_cfg.
REQ-035 Sub-module uart_baud_tick (parameter DIV, inputs clk, rst, restart; output tick) SHALL provide the oversample tick.

Verification (sim params INPUT_CLOCK_FREQ=1_600_000, BAUD_RATE=10_000, OVERSAMPLE=16 -> TICK_DIV=10)
REQ-036 8N1, send 0xA5, dout_ready=1 -> dout=0xA5, dout_valid one clock, no flags.
REQ-037 8E1, send 0x3C with parity bit 1 -> dout=0x3C, parity_err=1, frame_err=0.
REQ-038 din low 60 clocks (<half bit) then high -> no dout_valid, state back to IDLE.
REQ-039 8N2, send 0x55 with second stop bit 0 -> dout=0x55, frame_err=1.
REQ-040 dout_ready=0, send 0x11 then 0x22 -> dout stays 0x11, overrun pulses once; raise ready -> dout_valid clears next clock.
REQ-041 7O1, send 0x7F, assert rst low mid-DATA for 3 clocks, then send 0x01 -> only 0x01 delivered, parity_err=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types and helpers for the receive (and future transmit) front ends.
package uart_pkg;

  typedef enum logic [1:0] {
    PARITY_NONE,
    PARITY_ODD,
    PARITY_EVEN
  } parity_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  function automatic int calc_tick_div(input int clk_hz, input int baud, input int os);
    return clk_hz / (baud * os);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clock pulse every DIV clocks, realigned by restart.
module uart_baud_tick #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  // Down-counter; terminal count 0 fires the tick and reloads.
  always_comb begin
    tick  = 1'b0;
    cnt_d = cnt_q - CW'(1);
    if (restart) begin
      cnt_d = CW'(DIV - 1);
    end else if (cnt_q == '0) begin
      tick  = 1'b1;
      cnt_d = CW'(DIV - 1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable oversampling UART receiver with a one-word holding register.
//   state     | meaning
//   RX_IDLE   | line idle, waiting for synchronized din low
//   RX_START  | validating start bit at mid-bit (false start returns to idle)
//   RX_DATA   | shifting DATA_BITS data bits, LSB first
//   RX_PARITY | checking the parity bit
//   RX_STOP   | checking stop bits; frame completes at last stop mid-bit
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int      INPUT_CLOCK_FREQ = 100_000_000,
  parameter int      BAUD_RATE        = 9600,
  parameter int      OVERSAMPLE       = 16,
  parameter int      DATA_BITS        = 8,
  parameter parity_t PARITY           = PARITY_NONE,
  parameter int      STOP_BITS        = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 din,
  output logic [DATA_BITS-1:0] dout,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int TICK_DIV = calc_tick_div(INPUT_CLOCK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int TCW      = $clog2(OVERSAMPLE);
  localparam int BCW      = $clog2(DATA_BITS);

  if (TICK_DIV < 2 || OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0 ||
      DATA_BITS < 5 || DATA_BITS > 9 || !(STOP_BITS == 1 || STOP_BITS == 2)) begin : g_param_check
    $error("uart_rx_cfg: illegal parameter combination");
  end

  rx_state_t            state_q, state_d;
  logic                 sync1_q, sync1_d, sync2_q, sync2_d;
  logic [TCW-1:0]       tcnt_q, tcnt_d;
  logic [1:0]           smp_q, smp_d;
  logic [BCW-1:0]       bidx_q, bidx_d;
  logic                 sidx_q, sidx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 perr_q, perr_d, ferr_q, ferr_d;
  logic [DATA_BITS-1:0] dout_q, dout_d;
  logic                 dval_q, dval_d, dperr_q, dperr_d, dferr_q, dferr_d, ovr_q, ovr_d;

  logic din_s, tick, restart, at_mid, at_end, maj, last_data, last_stop, frame_done;

  assign din_s      = sync2_q;
  assign restart    = (state_q == RX_IDLE) && !din_s;
  assign at_mid     = tick && (tcnt_q == TCW'(OVERSAMPLE/2 + 1));
  assign at_end     = tick && (tcnt_q == TCW'(OVERSAMPLE - 1));
  assign maj        = (smp_q[0] & smp_q[1]) | (smp_q[0] & din_s) | (smp_q[1] & din_s);
  assign last_data  = (bidx_q == BCW'(DATA_BITS - 1));
  assign last_stop  = (sidx_q == 1'(STOP_BITS - 1));
  assign frame_done = (state_q == RX_STOP) && at_mid && last_stop;

  uart_baud_tick #(.DIV(TICK_DIV)) u_baud_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .tick    (tick)
  );

  always_ff @(posedge clk) begin
    if (!rst) state_q <= RX_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RX_IDLE:   if (!din_s) state_d = RX_START;
      RX_START:  if (at_mid && maj) state_d = RX_IDLE;
                 else if (at_end) state_d = RX_DATA;
      RX_DATA:   if (at_end && last_data)
                   state_d = (PARITY != PARITY_NONE) ? RX_PARITY : RX_STOP;
      RX_PARITY: if (at_end) state_d = RX_STOP;
      RX_STOP:   if (frame_done) state_d = RX_IDLE;
      default:   state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    sync1_d = din;
    sync2_d = sync1_q;
    tcnt_d  = tcnt_q;
    smp_d   = smp_q;
    bidx_d  = bidx_q;
    sidx_d  = sidx_q;
    shreg_d = shreg_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    dout_d  = dout_q;
    dval_d  = dval_q;
    dperr_d = dperr_q;
    dferr_d = dferr_q;
    ovr_d   = 1'b0;

    // Counters sit at zero in idle, so the start transition begins at tick 0.
    if (state_q == RX_IDLE) begin
      tcnt_d = '0;
      bidx_d = '0;
      sidx_d = '0;
      perr_d = 1'b0;
      ferr_d = 1'b0;
    end else if (tick) begin
      tcnt_d = (tcnt_q == TCW'(OVERSAMPLE - 1)) ? '0 : tcnt_q + TCW'(1);
      if (tcnt_q == TCW'(OVERSAMPLE/2 - 1)) smp_d[0] = din_s;
      if (tcnt_q == TCW'(OVERSAMPLE/2))     smp_d[1] = din_s;
    end

    if (at_mid) begin
      case (state_q)
        RX_DATA:   shreg_d = {maj, shreg_q[DATA_BITS-1:1]};
        RX_PARITY: perr_d  = maj ^ (^shreg_q) ^ (PARITY == PARITY_ODD);
        RX_STOP:   if (!maj) ferr_d = 1'b1;
        default:   ;
      endcase
    end

    if (at_end && state_q == RX_DATA) bidx_d = bidx_q + BCW'(1);
    if (at_end && state_q == RX_STOP) sidx_d = sidx_q + 1'b1;

    if (dval_q && dout_ready) dval_d = 1'b0;

    // A completed frame is only dropped when the held word is not leaving this clock.
    if (frame_done) begin
      if (!dval_q || dout_ready) begin
        dout_d  = shreg_q;
        dval_d  = 1'b1;
        dperr_d = (PARITY != PARITY_NONE) && perr_q;
        dferr_d = ferr_q | ~maj;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      tcnt_q  <= '0;
      smp_q   <= '0;
      bidx_q  <= '0;
      sidx_q  <= 1'b0;
      shreg_q <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      dout_q  <= '0;
      dval_q  <= 1'b0;
      dperr_q <= 1'b0;
      dferr_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      tcnt_q  <= tcnt_d;
      smp_q   <= smp_d;
      bidx_q  <= bidx_d;
      sidx_q  <= sidx_d;
      shreg_q <= shreg_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      dout_q  <= dout_d;
      dval_q  <= dval_d;
      dperr_q <= dperr_d;
      dferr_q <= dferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dval_q;
  assign parity_err = dperr_q;
  assign frame_err  = dferr_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg across 8N1, 8E1, 8N2 and 7O1 configurations.
module tb_uart_rx_cfg;
  import uart_pkg::*;

  localparam int BIT_CLKS = 160;

  typedef struct packed {
    logic [1:0] unit;
    logic [8:0] data;
    logic       pe;
    logic       fe;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] din, rdy, vld, perr, ferr, ovr;
  logic [7:0] dout0, dout1, dout2;
  logic [6:0] dout3;

  int   errors = 0;
  int   checks = 0;
  int   ovr_cnt [4];
  int   vld_cyc [4];
  rec_t exp_q[$];
  rec_t got_q[$];

  always #5 clk = ~clk;

  uart_rx_cfg #(.INPUT_CLOCK_FREQ(1_600_000), .BAUD_RATE(10_000), .OVERSAMPLE(16),
                .DATA_BITS(8), .PARITY(PARITY_NONE), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst(rst), .din(din[0]), .dout(dout0), .dout_valid(vld[0]),
    .dout_ready(rdy[0]), .parity_err(perr[0]), .frame_err(ferr[0]), .overrun(ovr[0]));

  uart_rx_cfg #(.INPUT_CLOCK_FREQ(1_600_000), .BAUD_RATE(10_000), .OVERSAMPLE(16),
                .DATA_BITS(8), .PARITY(PARITY_EVEN), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst(rst), .din(din[1]), .dout(dout1), .dout_valid(vld[1]),
    .dout_ready(rdy[1]), .parity_err(perr[1]), .frame_err(ferr[1]), .overrun(ovr[1]));

  uart_rx_cfg #(.INPUT_CLOCK_FREQ(1_600_000), .BAUD_RATE(10_000), .OVERSAMPLE(16),
                .DATA_BITS(8), .PARITY(PARITY_NONE), .STOP_BITS(2)) u_8n2 (
    .clk(clk), .rst(rst), .din(din[2]), .dout(dout2), .dout_valid(vld[2]),
    .dout_ready(rdy[2]), .parity_err(perr[2]), .frame_err(ferr[2]), .overrun(ovr[2]));

  uart_rx_cfg #(.INPUT_CLOCK_FREQ(1_600_000), .BAUD_RATE(10_000), .OVERSAMPLE(16),
                .DATA_BITS(7), .PARITY(PARITY_ODD), .STOP_BITS(1)) u_7o1 (
    .clk(clk), .rst(rst), .din(din[3]), .dout(dout3), .dout_valid(vld[3]),
    .dout_ready(rdy[3]), .parity_err(perr[3]), .frame_err(ferr[3]), .overrun(ovr[3]));

  function automatic logic [8:0] dout_of(input int k);
    case (k)
      0:       return {1'b0, dout0};
      1:       return {1'b0, dout1};
      2:       return {1'b0, dout2};
      default: return {2'b00, dout3};
    endcase
  endfunction

  // Collect every accepted word (valid && ready at the coming edge).
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      for (int k = 0; k < 4; k++) begin
        if (vld[k]) vld_cyc[k] <= vld_cyc[k] + 1;
        if (ovr[k]) ovr_cnt[k] <= ovr_cnt[k] + 1;
        if (vld[k] && rdy[k]) begin
          rec_t r;
          r.unit = 2'(k);
          r.data = dout_of(k);
          r.pe   = perr[k];
          r.fe   = ferr[k];
          got_q.push_back(r);
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_got(input int n);
    for (int i = 0; i < 3000 && got_q.size() < n; i++) @(negedge clk);
  endtask

  // pmode: 0 none, 1 odd, 2 even. pflip sends the wrong parity bit.
  task automatic send_frame(input int k, input logic [8:0] data, input int nbits, input int pmode,
                            input bit pflip, input int nstop, input logic [1:0] stops,
                            input bit expect_out);
    logic p, fe;
    rec_t r;
    p = ^data;
    if (pmode == 1) p = ~p;
    p = p ^ pflip;
    fe = 1'b0;
    for (int i = 0; i < nstop; i++) if (!stops[i]) fe = 1'b1;
    if (expect_out) begin
      r.unit = 2'(k);
      r.data = data;
      r.pe   = (pmode != 0) && pflip;
      r.fe   = fe;
      exp_q.push_back(r);
    end
    din[k] = 1'b0;
    cycles(BIT_CLKS);
    for (int i = 0; i < nbits; i++) begin
      din[k] = data[i];
      cycles(BIT_CLKS);
    end
    if (pmode != 0) begin
      din[k] = p;
      cycles(BIT_CLKS);
    end
    for (int i = 0; i < nstop; i++) begin
      din[k] = stops[i];
      cycles(BIT_CLKS);
    end
    din[k] = 1'b1;
    cycles(BIT_CLKS);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    din = 4'b0000;
    rdy = 4'b1111;
    cycles(4);
    @(negedge clk);
    checks++;
    if ({vld, perr, ferr, ovr} !== 16'h0000) begin
      errors++;
      $display("FAIL reset_flags: got vld/perr/ferr/ovr=%h required 0000", {vld, perr, ferr, ovr});
    end
    checks++;
    if ({dout0, dout1, dout2, dout3} !== 31'h0) begin
      errors++;
      $display("FAIL reset_dout: got %h required 0", {dout0, dout1, dout2, dout3});
    end
    checks++;
    if (u_8n1.state_q !== RX_IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d required %0d", u_8n1.state_q, RX_IDLE);
    end
    checks++;
    if (u_8n1.sync2_q !== 1'b1) begin
      errors++;
      $display("FAIL reset_sync: got %b required 1", u_8n1.sync2_q);
    end
    din = 4'b1111;
    cycles(2);
    rst = 1'b1;
    cycles(BIT_CLKS);
  endtask

  task automatic test_8n1();
    int v0;
    int o0;
    rec_t e, g;
    v0 = vld_cyc[0];
    o0 = ovr_cnt[0];
    send_frame(0, 9'h0A5, 8, 0, 1'b0, 1, 2'b11, 1'b1);
    wait_got(1);
    checks++;
    if (got_q.size() < 1) begin
      errors++;
      $display("FAIL 8n1_delivery: got %0d words required 1", got_q.size());
    end else begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL 8n1_word: got unit=%0d data=%h pe=%b fe=%b required unit=%0d data=%h pe=%b fe=%b",
                 g.unit, g.data, g.pe, g.fe, e.unit, e.data, e.pe, e.fe);
      end
    end
    cycles(4);
    checks++;
    if (vld_cyc[0] - v0 !== 1) begin
      errors++;
      $display("FAIL 8n1_valid_len: got %0d cycles required 1", vld_cyc[0] - v0);
    end
    checks++;
    if (ovr_cnt[0] !== o0) begin
      errors++;
      $display("FAIL 8n1_overrun: got %0d pulses required 0", ovr_cnt[0] - o0);
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] pats [3];
    rec_t e, g;
    pats[0] = 9'h000;
    pats[1] = 9'h0FF;
    pats[2] = 9'h05A;
    for (int i = 0; i < 3; i++) send_frame(0, pats[i], 8, 0, 1'b0, 1, 2'b11, 1'b1);
    wait_got(3);
    checks++;
    if (got_q.size() != 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d words required 3", got_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL b2b_word: got data=%h pe=%b fe=%b required data=%h pe=%b fe=%b",
                 g.data, g.pe, g.fe, e.data, e.pe, e.fe);
      end
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_false_start();
    int v0;
    v0 = vld_cyc[0];
    din[0] = 1'b0;
    cycles(60);
    din[0] = 1'b1;
    cycles(3 * BIT_CLKS);
    checks++;
    if (vld_cyc[0] !== v0 || got_q.size() != 0) begin
      errors++;
      $display("FAIL false_start_output: got %0d valid cycles required 0", vld_cyc[0] - v0);
    end
    checks++;
    if (u_8n1.state_q !== RX_IDLE) begin
      errors++;
      $display("FAIL false_start_state: got %0d required %0d", u_8n1.state_q, RX_IDLE);
    end
  endtask

  task automatic test_parity_even();
    rec_t e, g;
    send_frame(1, 9'h03C, 8, 2, 1'b1, 1, 2'b11, 1'b1);
    send_frame(1, 9'h03C, 8, 2, 1'b0, 1, 2'b11, 1'b1);
    send_frame(1, 9'h081, 8, 2, 1'b0, 1, 2'b11, 1'b1);
    wait_got(3);
    checks++;
    if (got_q.size() != 3) begin
      errors++;
      $display("FAIL parity_count: got %0d words required 3", got_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL parity_word: got data=%h pe=%b fe=%b required data=%h pe=%b fe=%b",
                 g.data, g.pe, g.fe, e.data, e.pe, e.fe);
      end
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_frame_err();
    rec_t e, g;
    send_frame(2, 9'h055, 8, 0, 1'b0, 2, 2'b01, 1'b1);
    send_frame(2, 9'h0C3, 8, 0, 1'b0, 2, 2'b11, 1'b1);
    send_frame(2, 9'h0E7, 8, 0, 1'b0, 2, 2'b10, 1'b1);
    wait_got(3);
    cycles(2 * BIT_CLKS);
    checks++;
    if (got_q.size() != 3) begin
      errors++;
      $display("FAIL frame_count: got %0d words required 3", got_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL frame_word: got data=%h pe=%b fe=%b required data=%h pe=%b fe=%b",
                 g.data, g.pe, g.fe, e.data, e.pe, e.fe);
      end
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_overrun();
    int o0;
    rec_t e, g;
    o0 = ovr_cnt[0];
    rdy[0] = 1'b0;
    send_frame(0, 9'h011, 8, 0, 1'b0, 1, 2'b11, 1'b1);
    send_frame(0, 9'h022, 8, 0, 1'b0, 1, 2'b11, 1'b0);
    @(negedge clk);
    checks++;
    if (vld[0] !== 1'b1 || dout0 !== 8'h11) begin
      errors++;
      $display("FAIL overrun_hold: got valid=%b dout=%h required valid=1 dout=11", vld[0], dout0);
    end
    checks++;
    if (ovr_cnt[0] - o0 !== 1) begin
      errors++;
      $display("FAIL overrun_pulses: got %0d required 1", ovr_cnt[0] - o0);
    end
    cycles(1);
    rdy[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (vld[0] !== 1'b0) begin
      errors++;
      $display("FAIL overrun_release: got valid=%b required 0", vld[0]);
    end
    wait_got(1);
    checks++;
    if (got_q.size() != 1) begin
      errors++;
      $display("FAIL overrun_count: got %0d words required 1", got_q.size());
    end else begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL overrun_word: got data=%h pe=%b fe=%b required data=%h pe=%b fe=%b",
                 g.data, g.pe, g.fe, e.data, e.pe, e.fe);
      end
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_reset_mid_frame();
    rec_t e, g;
    din[3] = 1'b0;
    cycles(BIT_CLKS);
    din[3] = 1'b1;
    cycles(3 * BIT_CLKS + BIT_CLKS / 2);
    checks++;
    if (u_7o1.state_q !== RX_DATA) begin
      errors++;
      $display("FAIL abort_precond: got state %0d required %0d", u_7o1.state_q, RX_DATA);
    end
    rst = 1'b0;
    cycles(3);
    rst = 1'b1;
    cycles(2 * BIT_CLKS);
    checks++;
    if (u_7o1.state_q !== RX_IDLE || vld[3] !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: got state %0d valid %b required %0d and 0",
               u_7o1.state_q, vld[3], RX_IDLE);
    end
    send_frame(3, 9'h001, 7, 1, 1'b0, 1, 2'b11, 1'b1);
    wait_got(1);
    cycles(2 * BIT_CLKS);
    checks++;
    if (got_q.size() != 1) begin
      errors++;
      $display("FAIL abort_count: got %0d words required 1", got_q.size());
    end else begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL abort_word: got unit=%0d data=%h pe=%b fe=%b required unit=%0d data=%h pe=%b fe=%b",
                 g.unit, g.data, g.pe, g.fe, e.unit, e.data, e.pe, e.fe);
      end
    end
    exp_q.delete();
    got_q.delete();
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_back_to_back();
    test_false_start();
    test_parity_even();
    test_frame_err();
    test_overrun();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
